bram_loader: RTL

Streaming operand loader: accepts a word-serial operand stream over a valid/ready handshake, packs `DBITS/WBITS` words into one BRAM line, and writes consecutive lines into the operand BRAM through its second write port (`WR_ADDR2`/`WR_DATA2`/`WR_EN2`). It is the producer side of the operand store that `mon_prod` reads from. It replaces host/bench pokes of A, B and similar operands with a sequenced hardware writer.

---
 rtl/bram_loader_pkg.sv | 20 ++
 rtl/line_packer.sv | 44 ++++
 rtl/bram_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/bram_loader_pkg.sv
// Shared definitions for the operand store: mon_prod opcodes and loader types.
package bram_loader_pkg;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FIN
  } loader_state_t;

  function automatic int unsigned words_per_line(input int unsigned dbits,
                                                 input int unsigned wbits);
    return dbits / wbits;
  endfunction

endpackage

// File: rtl/line_packer.sv
// Packs WBITS-wide input words into one DBITS-wide line, word 0 least significant.
module line_packer
  import bram_loader_pkg::*;
#(
  parameter int unsigned DBITS = 512,
  parameter int unsigned WBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic [WBITS-1:0] in_data,
  output logic [DBITS-1:0] line_next,
  output logic             line_full
);

  localparam int unsigned WPL  = words_per_line(DBITS, WBITS);
  localparam int unsigned IDXW = (WPL > 1) ? $clog2(WPL) : 1;

  logic [DBITS-1:0] line_q;
  logic [IDXW-1:0]  word_idx;

  // line_next already contains the word being accepted, so the loader can
  // register the complete line on the same edge as the last handshake.
  always_comb begin
    line_next = line_q;
    if (accept) line_next[word_idx*WBITS +: WBITS] = in_data;
  end

  assign line_full = accept && (word_idx == IDXW'(WPL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q   <= '0;
      word_idx <= '0;
    end else begin
      line_q <= line_next;
      if (clr)            word_idx <= '0;
      else if (line_full) word_idx <= '0;
      else if (accept)    word_idx <= word_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/bram_loader.sv
// Sequenced writer: streams words in, writes packed lines to the BRAM second port.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int unsigned ABITS = 8,
  parameter int unsigned DBITS = 512,
  parameter int unsigned WBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [ABITS:0]   n_lines,
  input  logic             in_valid,
  input  logic [WBITS-1:0] in_data,
  output logic             in_ready,
  output logic [ABITS-1:0] wr_addr,
  output logic [DBITS-1:0] wr_data,
  output logic             wr_en,
  output logic             busy,
  output logic             done
);

  loader_state_t    state;
  logic [ABITS-1:0] base_q;
  logic [ABITS:0]   n_q;
  logic [ABITS:0]   line_idx;
  logic             accept;
  logic             clr;
  logic             last_line;
  logic             line_full;
  logic [DBITS-1:0] line_next;

  assign accept    = in_valid && in_ready;
  assign last_line = (line_idx == n_q - (ABITS+1)'(1));
  assign clr       = ((state == S_IDLE) && start) || ((state == S_WRITE) && !last_line);

  line_packer #(
    .DBITS (DBITS),
    .WBITS (WBITS)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .accept    (accept),
    .in_data   (in_data),
    .line_next (line_next),
    .line_full (line_full)
  );

  // Outputs are registered on the transition into each state, so wr_en and
  // done are high during the WRITE/FIN cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      n_q      <= '0;
      line_idx <= '0;
      in_ready <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            n_q      <= n_lines;
            line_idx <= '0;
            busy     <= 1'b1;
            if (n_lines == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (line_full) begin
            state    <= S_WRITE;
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_addr  <= base_q + line_idx[ABITS-1:0];
            wr_data  <= line_next;
            done     <= last_line;
          end
        end
        S_WRITE: begin
          if (last_line) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_LOAD;
            line_idx <= line_idx + (ABITS+1)'(1);
            in_ready <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
